tone_direction_decoder: RTL and testbench

- Decodes the five band-pass comparator inputs (bp1..bp5) into the junction command consumed by the drive state machine: tdEn (command valid) and tdDir (STRAIGHT/LEFT/RIGHT/BACK).
- Each channel's edge rate is measured over a fixed window.
- A direction is accepted only while the bp5 beacon tone is present and exactly one direction tone is present.
- The same command must be seen for several consecutive windows before tdEn is asserted, and it is released through a hold/miss counter.

---
 rtl/tone_direction_decoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_tone_direction_decoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_direction_decoder.sv
// Tone direction decoder: measures rising-edge rates of five band-pass
// comparator channels over fixed windows, classifies each window, and turns a
// persistent single-direction tone (with the bp5 beacon) into a junction
// command for the drive state machine.
//
// Handshake: tdEn is a level "command valid"; tdDir is stable whenever tdEn=1
// and only changes on the cycle tdEn rises, which is also the one cycle
// tdStrobe is high. There is no ready/back-pressure: the consumer samples.
module tone_direction_decoder #(
  parameter int WINDOW_CYCLES   = 500_000,
  parameter int MIN_EDGES       = 8,
  parameter int MAX_EDGES       = 200,
  parameter int CONFIRM_WINDOWS = 3,
  parameter int HOLD_WINDOWS    = 2
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic       tdStrobe,
  output logic [4:0] tdChan
);

  localparam int WCW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int CCW = $clog2(CONFIRM_WINDOWS + 1);
  localparam int HCW = $clog2(HOLD_WINDOWS + 1);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic [4:0]       w_bp;
  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic [4:0]       r_prev;
  logic [4:0]       r_edge;
  logic [WCW-1:0]   r_win_cnt;
  logic             w_win_end;
  logic [4:0][9:0]  r_cnt;
  logic [4:0][9:0]  w_cnt_next;
  logic [4:0]       w_active;
  logic [2:0]       w_dir_cnt;
  logic             w_valid;
  logic             w_conflict;
  logic [1:0]       w_code;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_cand;
  logic [1:0]       w_cand_next;
  logic [CCW-1:0]   r_confirm;
  logic [CCW-1:0]   w_confirm_next;
  logic [HCW-1:0]   r_miss;
  logic [HCW-1:0]   w_miss_next;
  logic             r_en;
  logic             w_en_next;
  logic [1:0]       r_dir;
  logic [1:0]       w_dir_next;
  logic             r_strobe;
  logic             w_strobe_next;
  logic [4:0]       r_chan;

  assign w_bp = {bp5, bp4, bp3, bp2, bp1};

  // Two-flop synchronizer per channel followed by a registered rising-edge detect.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_edge  <= '0;
    end else begin
      r_sync1 <= w_bp;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= r_sync2 & ~r_prev;
    end
  end

  assign w_win_end = (r_win_cnt == WIN_LAST);

  // Free-running window counter, 0..WINDOW_CYCLES-1.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_win_cnt <= '0;
    end else if (w_win_end) begin
      r_win_cnt <= '0;
    end else begin
      r_win_cnt <= r_win_cnt + WCW'(1);
    end
  end

  // Saturating edge count including this cycle's edge, and the activity test on it.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (r_edge[i] && (r_cnt[i] != 10'h3FF)) begin
        w_cnt_next[i] = r_cnt[i] + 10'd1;
      end
      w_active[i] = (w_cnt_next[i] >= 10'(MIN_EDGES)) &&
                    (w_cnt_next[i] <= 10'(MAX_EDGES));
    end
  end

  // Edge counters; cleared at window end so the next window starts from zero.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_cnt <= '0;
    end else if (w_win_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // Window classification: beacon plus exactly one direction tone is valid.
  always_comb begin
    w_dir_cnt  = {2'b00, w_active[0]} + {2'b00, w_active[1]} +
                 {2'b00, w_active[2]} + {2'b00, w_active[3]};
    w_valid    = w_active[4] && (w_dir_cnt == 3'd1);
    w_conflict = w_active[4] && (w_dir_cnt >= 3'd2);
    case (w_active[3:0])
      4'b0010: w_code = 2'b01;
      4'b0100: w_code = 2'b10;
      4'b1000: w_code = 2'b11;
      default: w_code = 2'b00;
    endcase
  end

  // Next-state and next-output logic; only window-end cycles move the FSM.
  always_comb begin
    w_state_next   = r_state;
    w_cand_next    = r_cand;
    w_confirm_next = r_confirm;
    w_miss_next    = r_miss;
    w_en_next      = r_en;
    w_dir_next     = r_dir;
    if (w_win_end) begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            w_cand_next    = w_code;
            w_confirm_next = CCW'(1);
            if (CONFIRM_WINDOWS == 1) begin
              w_state_next = ST_LOCKED;
              w_en_next    = 1'b1;
              w_dir_next   = w_code;
              w_miss_next  = '0;
            end else begin
              w_state_next = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (w_valid) begin
            if (w_code == r_cand) begin
              if ((int'(r_confirm) + 1) >= CONFIRM_WINDOWS) begin
                w_state_next   = ST_LOCKED;
                w_en_next      = 1'b1;
                w_dir_next     = r_cand;
                w_miss_next    = '0;
                w_confirm_next = '0;
              end else begin
                w_confirm_next = r_confirm + CCW'(1);
              end
            end else begin
              w_cand_next    = w_code;
              w_confirm_next = CCW'(1);
            end
          end else begin
            w_state_next   = ST_IDLE;
            w_confirm_next = '0;
          end
        end
        ST_LOCKED: begin
          if (w_conflict) begin
            w_state_next = ST_IDLE;
            w_en_next    = 1'b0;
            w_miss_next  = '0;
          end else if (w_valid && (w_code == r_dir)) begin
            w_miss_next = '0;
          end else if (w_valid) begin
            // New direction: drop the command but keep tdDir until the next lock.
            w_state_next   = ST_CONFIRM;
            w_cand_next    = w_code;
            w_confirm_next = CCW'(1);
            w_en_next      = 1'b0;
            w_miss_next    = '0;
          end else if ((int'(r_miss) + 1) >= HOLD_WINDOWS) begin
            w_state_next = ST_IDLE;
            w_en_next    = 1'b0;
            w_miss_next  = '0;
          end else begin
            w_miss_next = r_miss + HCW'(1);
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_en_next    = 1'b0;
        end
      endcase
    end
    w_strobe_next = w_en_next & ~r_en;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state   <= ST_IDLE;
      r_cand    <= '0;
      r_confirm <= '0;
      r_miss    <= '0;
      r_en      <= 1'b0;
      r_dir     <= '0;
      r_strobe  <= 1'b0;
      r_chan    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cand    <= w_cand_next;
      r_confirm <= w_confirm_next;
      r_miss    <= w_miss_next;
      r_en      <= w_en_next;
      r_dir     <= w_dir_next;
      r_strobe  <= w_strobe_next;
      if (w_win_end) begin
        r_chan <= w_active;
      end
    end
  end

  assign tdEn     = r_en;
  assign tdDir    = r_dir;
  assign tdStrobe = r_strobe;
  assign tdChan   = r_chan;

endmodule

// File: tb/tb_tone_direction_decoder.sv
// Bench for tone_direction_decoder: drives per-window edge bursts on the five
// tone inputs and compares window-end outputs against a window-level model.
module tb_tone_direction_decoder;

  localparam int WIN     = 100;
  localparam int MINE    = 4;
  localparam int MAXE    = 30;
  localparam int CONF    = 3;
  localparam int HOLD    = 2;
  localparam int LAT     = 3;
  localparam int P_START = 5;
  localparam int P_END   = 85;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN;
  logic bp1, bp2, bp3, bp4, bp5;
  logic       tdEn;
  logic [1:0] tdDir;
  logic       tdStrobe;
  logic [4:0] tdChan;

  always #5 clk = ~clk;

  logic [4:0] bp_drv;
  logic [4:0] bp_prev;
  assign {bp5, bp4, bp3, bp2, bp1} = bp_drv;

  tone_direction_decoder #(
    .WINDOW_CYCLES(WIN),
    .MIN_EDGES(MINE),
    .MAX_EDGES(MAXE),
    .CONFIRM_WINDOWS(CONF),
    .HOLD_WINDOWS(HOLD)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .bp1(bp1),
    .bp2(bp2),
    .bp3(bp3),
    .bp4(bp4),
    .bp5(bp5),
    .tdEn(tdEn),
    .tdDir(tdDir),
    .tdStrobe(tdStrobe),
    .tdChan(tdChan)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];  // {en, dir[1:0], strobe, chan[4:0]}

  int         cfg_n[5];
  logic [4:0] cfg_late_mask;
  int         cfg_late_c;
  int         cur_cnt[5];
  int         nxt_cnt[5];
  int         rnd_dir;

  typedef enum int { M_IDLE, M_CONFIRM, M_LOCKED } mstate_e;
  mstate_e    m_st;
  int         m_cand;
  int         m_conf;
  int         m_miss;
  logic       m_en;
  logic [1:0] m_dir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_st = M_IDLE;
    m_cand = 0;
    m_conf = 0;
    m_miss = 0;
    m_en = 1'b0;
    m_dir = 2'b00;
    for (int i = 0; i < 5; i++) begin
      cur_cnt[i] = 0;
      nxt_cnt[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_lock();
    m_st = M_LOCKED;
    m_en = 1'b1;
    m_dir = 2'(m_cand);
    m_miss = 0;
  endtask

  // Applies one completed window's edge counts to the model and queues expectations.
  task automatic model_window();
    logic [4:0] act;
    int nd;
    int code;
    logic valid;
    logic conflict;
    logic old_en;
    nd = 0;
    code = 0;
    for (int i = 0; i < 5; i++) act[i] = (cur_cnt[i] >= MINE) && (cur_cnt[i] <= MAXE);
    for (int i = 0; i < 4; i++) if (act[i]) begin nd++; code = i; end
    valid    = act[4] && (nd == 1);
    conflict = act[4] && (nd >= 2);
    old_en   = m_en;
    case (m_st)
      M_IDLE: begin
        if (valid) begin
          m_cand = code;
          m_conf = 1;
          if (CONF == 1) model_lock();
          else m_st = M_CONFIRM;
        end
      end
      M_CONFIRM: begin
        if (valid && code == m_cand) begin
          m_conf++;
          if (m_conf >= CONF) model_lock();
        end else if (valid) begin
          m_cand = code;
          m_conf = 1;
        end else begin
          m_st = M_IDLE;
          m_conf = 0;
        end
      end
      default: begin
        if (conflict) begin
          m_st = M_IDLE; m_en = 1'b0; m_miss = 0;
        end else if (valid && code == int'(m_dir)) begin
          m_miss = 0;
        end else if (valid) begin
          m_st = M_CONFIRM; m_cand = code; m_conf = 1; m_en = 1'b0; m_miss = 0;
        end else begin
          m_miss++;
          if (m_miss >= HOLD) begin
            m_st = M_IDLE; m_en = 1'b0; m_miss = 0;
          end
        end
      end
    endcase
    exp_q.push_back({m_en, m_dir, m_en & ~old_en, act});
    for (int i = 0; i < 5; i++) begin
      cur_cnt[i] = nxt_cnt[i];
      nxt_cnt[i] = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [4:0] pattern(input int c);
    logic [4:0] v;
    v = '0;
    for (int i = 0; i < 5; i++) begin
      if (c >= P_START && c < P_END && ((c - P_START) % 2 == 0) &&
          ((c - P_START) / 2 < cfg_n[i])) v[i] = 1'b1;
      if (c == cfg_late_c && cfg_late_mask[i]) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic set_cfg(input int n1, input int n2, input int n3, input int n4, input int n5);
    cfg_n[0] = n1; cfg_n[1] = n2; cfg_n[2] = n3; cfg_n[3] = n4; cfg_n[4] = n5;
    cfg_late_mask = '0;
    cfg_late_c = -1;
  endtask

  // Called at the falling edge of window cycle 0; returns at cycle 0 of the next window.
  task automatic run_window();
    logic [8:0] e;
    for (int c = 0; c < WIN; c++) begin
      if (c == 1) chk("strobe_one_cycle", {31'd0, tdStrobe}, 32'd0);
      if (c == 50) begin
        chk("en_hold", {31'd0, tdEn}, {31'd0, m_en});
        chk("dir_hold", {30'd0, tdDir}, {30'd0, m_dir});
      end
      bp_drv = pattern(c);
      for (int i = 0; i < 5; i++) begin
        if (bp_drv[i] && !bp_prev[i]) begin
          if (c + LAT <= WIN - 1) cur_cnt[i]++;
          else nxt_cnt[i]++;
        end
      end
      bp_prev = bp_drv;
      @(negedge clk);
    end
    model_window();
    e = exp_q.pop_front();
    chk("tdEn", {31'd0, tdEn}, {31'd0, e[8]});
    chk("tdDir", {30'd0, tdDir}, {30'd0, e[7:6]});
    chk("tdStrobe", {31'd0, tdStrobe}, {31'd0, e[5]});
    chk("tdChan", {27'd0, tdChan}, {27'd0, e[4:0]});
  endtask

  // Asserts reset for n cycles with random inputs; returns at window cycle 0.
  task automatic do_reset(input int n);
    rstN = 1'b0;
    bp_drv = 5'($urandom);
    @(negedge clk);
    chk("rst_en", {31'd0, tdEn}, 32'd0);
    chk("rst_dir", {30'd0, tdDir}, 32'd0);
    chk("rst_strobe", {31'd0, tdStrobe}, 32'd0);
    chk("rst_chan", {27'd0, tdChan}, 32'd0);
    for (int k = 1; k < n; k++) begin
      bp_drv = 5'($urandom);
      @(negedge clk);
    end
    rstN = 1'b1;
    bp_drv = '0;
    bp_prev = '0;
    model_reset();
  endtask

  task automatic mid_window_reset(input int cut);
    for (int c = 0; c < cut; c++) begin
      bp_drv = pattern(c);
      @(negedge clk);
    end
    do_reset(4);
  endtask

  function automatic int pick_count();
    int t;
    t = $urandom_range(0, 5);
    case (t)
      0: return 0;
      1: return 3;
      2: return 4;
      3: return 30;
      4: return 31;
      default: return 10;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rstN = 1'b0;
    bp_drv = '0;
    bp_prev = '0;
    set_cfg(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    do_reset(5);

    // RIGHT lock after three windows
    set_cfg(0, 0, 10, 0, 10);
    repeat (3) run_window();

    // switch to LEFT, one absent window tolerated, then two absent windows release
    set_cfg(0, 10, 0, 0, 10);
    repeat (3) run_window();
    set_cfg(0, 0, 0, 0, 0);
    run_window();
    set_cfg(0, 10, 0, 0, 10);
    run_window();
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) run_window();

    // conflict from idle, then conflict while locked
    set_cfg(10, 10, 0, 0, 10);
    repeat (2) run_window();
    set_cfg(0, 10, 0, 0, 10);
    repeat (3) run_window();
    set_cfg(10, 10, 0, 0, 10);
    run_window();

    // activity thresholds on bp2
    set_cfg(0, 3, 0, 0, 10);
    run_window();
    set_cfg(0, 31, 0, 0, 10);
    run_window();
    set_cfg(0, 4, 0, 0, 10);
    run_window();
    set_cfg(0, 30, 0, 0, 10);
    run_window();

    // edge on the window-end cycle counts; one cycle later spills into the next window
    set_cfg(3, 0, 0, 0, 10);
    cfg_late_mask = 5'b00001;
    cfg_late_c = WIN - 1 - LAT;
    run_window();
    set_cfg(3, 0, 0, 0, 10);
    cfg_late_mask = 5'b00001;
    cfg_late_c = WIN - LAT;
    run_window();
    set_cfg(3, 0, 0, 0, 10);
    run_window();

    // STRAIGHT lock, then BACK takes over
    set_cfg(10, 0, 0, 0, 10);
    repeat (3) run_window();
    set_cfg(0, 0, 0, 10, 10);
    repeat (3) run_window();

    // randomized windows with a sticky direction
    rnd_dir = 0;
    repeat (16) begin
      if ($urandom_range(0, 3) == 0) rnd_dir = $urandom_range(0, 3);
      set_cfg(0, 0, 0, 0, ($urandom_range(0, 4) == 0) ? pick_count() : 10);
      cfg_n[rnd_dir] = ($urandom_range(0, 2) == 0) ? pick_count() : 10;
      if ($urandom_range(0, 5) == 0) cfg_n[(rnd_dir + 1) % 4] = pick_count();
      run_window();
    end

    // lock RIGHT, then reset mid-window and relock from a fresh window
    set_cfg(0, 0, 10, 0, 10);
    repeat (3) run_window();
    mid_window_reset(40);
    set_cfg(0, 0, 0, 10, 10);
    repeat (3) run_window();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
